// File: rtl/bnn_readout_pkg.sv
// bnn_readout_pkg: shared sizes, score types and FSM states for the BNN class readout
package bnn_readout_pkg;
    localparam int N_CLASSES = 10;
    localparam int SCORE_W   = 5;
    localparam int IDX_W     = $clog2(N_CLASSES);
    typedef logic [SCORE_W-1:0] score_t;
    typedef score_t [N_CLASSES-1:0] score_vec_t;
    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic [1:0] {IDLE, SCAN, HOLD} argmax_state_t;
endpackage

// File: rtl/bnn_class_argmax_if.sv
// bnn_class_argmax_if: result valid/ready handshake and payload towards the LCD/host side
interface bnn_class_argmax_if;
    import bnn_readout_pkg::*;
    logic   valid;
    logic   ready;
    idx_t   class_id;
    score_t score;
    logic   tie;
    score_t margin;
    modport master (output valid, class_id, score, tie, margin, input ready);
    modport slave  (input valid, class_id, score, tie, margin, output ready);
endinterface

// File: rtl/argmax_update.sv
// argmax_update: one combinational argmax step; second-best ports exist only with BNN_ARGMAX_MARGIN_EN
module argmax_update
    import bnn_readout_pkg::*;
(
    input  score_t best,
`ifdef BNN_ARGMAX_MARGIN_EN
    input  score_t second,
    output score_t second_nx,
`endif
    input  idx_t   cls,
    input  logic   tie,
    input  score_t cand,
    input  idx_t   idx,
    output score_t best_nx,
    output idx_t   cls_nx,
    output logic   tie_nx
);
    logic gt, eq;
    assign gt = cand > best;
    assign eq = cand == best;
    // Strictly larger takes over and clears any earlier tie; equal keeps the lower index but flags a tie
    always_comb begin
        best_nx = gt ? cand : best;
        cls_nx  = gt ? idx : cls;
        tie_nx  = gt ? 1'b0 : (eq ? 1'b1 : tie);
`ifdef BNN_ARGMAX_MARGIN_EN
        second_nx = (gt || eq) ? best : (cand > second ? cand : second);
`endif
    end
endmodule

// File: rtl/bnn_class_argmax.sv
// bnn_class_argmax: snapshots class scores and scans them one per cycle; margin output needs BNN_ARGMAX_MARGIN_EN
module bnn_class_argmax
    import bnn_readout_pkg::*;
(
    input  logic               usb_clk,
    input  logic               rst,
    input  score_vec_t         scores_i,
    input  logic               start_i,
    output logic               busy_o,
    output logic               overrun_o,
    bnn_class_argmax_if.master res
);
    argmax_state_t state, state_nx;
    score_vec_t snap;
    score_t best, best_nx, out_score;
    idx_t idx, cls, cls_nx, out_cls;
    logic tie, tie_nx, out_tie, fire, accept, last;
`ifdef BNN_ARGMAX_MARGIN_EN
    score_t second, second_nx, out_margin;
`endif

    assign fire   = (state == HOLD) && res.ready;
    assign accept = start_i && ((state == IDLE) || fire);
    // idx runs one past the last class so the result registers load on a dedicated cycle
    assign last   = (state == SCAN) && (idx == idx_t'(N_CLASSES));
    assign busy_o       = state != IDLE;
    assign res.valid    = state == HOLD;
    assign res.class_id = out_cls;
    assign res.score    = out_score;
    assign res.tie      = out_tie;
`ifdef BNN_ARGMAX_MARGIN_EN
    assign res.margin   = out_margin;
`else
    assign res.margin   = '0;
`endif

    argmax_update u_update (
        .best    (best),
`ifdef BNN_ARGMAX_MARGIN_EN
        .second    (second),
        .second_nx (second_nx),
`endif
        .cls     (cls),
        .tie     (tie),
        .cand    (snap[idx]),
        .idx     (idx),
        .best_nx (best_nx),
        .cls_nx  (cls_nx),
        .tie_nx  (tie_nx)
    );

    // State register
    always_ff @(posedge usb_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state: an accepted start wins even in the handshake cycle (back-to-back)
    always_comb begin
        state_nx = state;
        state_nx = accept ? SCAN : last ? HOLD : fire ? IDLE : state;
    end

    // Snapshot, running argmax, result registers and sticky overrun
    always_ff @(posedge usb_clk or posedge rst) begin
        if (rst) begin
            snap      <= '0;
            best      <= '0;
            cls       <= '0;
            tie       <= 1'b0;
            idx       <= '0;
            out_score <= '0;
            out_cls   <= '0;
            out_tie   <= 1'b0;
            overrun_o <= 1'b0;
`ifdef BNN_ARGMAX_MARGIN_EN
            second     <= '0;
            out_margin <= '0;
`endif
        end else begin
            if (accept) begin
                snap <= scores_i;
                best <= scores_i[0];
                cls  <= '0;
                tie  <= 1'b0;
                idx  <= idx_t'(1);
`ifdef BNN_ARGMAX_MARGIN_EN
                second <= '0;
`endif
            end else if (state == SCAN && !last) begin
                best <= best_nx;
                cls  <= cls_nx;
                tie  <= tie_nx;
                idx  <= idx + idx_t'(1);
`ifdef BNN_ARGMAX_MARGIN_EN
                second <= second_nx;
`endif
            end
            if (last) begin
                out_score <= best;
                out_cls   <= cls;
                out_tie   <= tie;
`ifdef BNN_ARGMAX_MARGIN_EN
                out_margin <= best - second;
`endif
            end
            if (start_i && ((state == SCAN) || (state == HOLD && !res.ready))) overrun_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bnn_class_argmax.sv
// tb_bnn_class_argmax: directed and random scans checked against a sort-based argmax model
module tb_bnn_class_argmax;
    import bnn_readout_pkg::*;

    logic       usb_clk = 1'b0;
    logic       rst = 1'b1;
    score_vec_t scores_i = '0;
    logic       start_i = 1'b0;
    logic       busy_o, overrun_o;
    int         checks = 0, errors = 0;
    int         exp_c, exp_s, exp_m;
    bit         exp_t;

    bnn_class_argmax_if ro ();

    bnn_class_argmax dut (
        .usb_clk   (usb_clk),
        .rst       (rst),
        .scores_i  (scores_i),
        .start_i   (start_i),
        .busy_o    (busy_o),
        .overrun_o (overrun_o),
        .res       (ro)
    );

    always #5 usb_clk = ~usb_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic score_vec_t mk(input int a[N_CLASSES]);
        score_vec_t v;
        for (int i = 0; i < N_CLASSES; i++) v[i] = score_t'(a[i]);
        return v;
    endfunction

    // Reference: sort the scores; max and runner-up come from the top of the sorted list
    function automatic void model(input score_vec_t v);
        int q[$];
        for (int i = 0; i < N_CLASSES; i++) q.push_back(int'(v[i]));
        q.sort();
        exp_s = q[N_CLASSES-1];
        exp_t = q[N_CLASSES-2] == exp_s;
        exp_m = exp_s - q[N_CLASSES-2];
`ifndef BNN_ARGMAX_MARGIN_EN
        exp_m = 0;
`endif
        exp_c = -1;
        for (int i = 0; i < N_CLASSES; i++) if (exp_c < 0 && int'(v[i]) == exp_s) exp_c = i;
    endfunction

    task automatic pulse(input score_vec_t v);
        scores_i = v;
        start_i = 1'b1;
        @(negedge usb_clk);
        start_i = 1'b0;
    endtask

    // Called half a cycle after the start edge; expects valid after exactly N_CLASSES edges
    task automatic wait_result(input score_vec_t v, input string tag);
        int n = 0;
        model(v);
        while (!ro.valid && n < 40) begin
            @(negedge usb_clk);
            n++;
        end
        chk({tag, "_lat"}, n, N_CLASSES);
        chk({tag, "_cls"}, ro.class_id, exp_c);
        chk({tag, "_score"}, ro.score, exp_s);
        chk({tag, "_tie"}, ro.tie, exp_t);
        chk({tag, "_margin"}, ro.margin, exp_m);
    endtask

    task automatic ack(input string tag);
        ro.ready = 1'b1;
        @(negedge usb_clk);
        ro.ready = 1'b0;
        chk({tag, "_vdrop"}, ro.valid, 0);
        chk({tag, "_held"}, ro.class_id, exp_c);
        chk({tag, "_idle"}, busy_o, 0);
    endtask

    initial begin
        score_vec_t v, hold_v;
        ro.ready = 1'b0;
        repeat (3) @(negedge usb_clk);
        chk("rst_valid", ro.valid, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_cls", ro.class_id, 0);
        chk("rst_score", ro.score, 0);
        chk("rst_ovr", overrun_o, 0);
        rst = 1'b0;
        @(negedge usb_clk);

        v = mk('{3, 7, 2, 9, 1, 0, 17, 5, 6, 4});
        pulse(v);
        chk("t1_busy", busy_o, 1);
        wait_result(v, "t1");
        ack("t1");

        v = mk('{1, 5, 0, 20, 3, 19, 2, 20, 4, 6});
        pulse(v); wait_result(v, "t2"); ack("t2");
        v = mk('{2, 9, 9, 0, 1, 12, 3, 4, 5, 6});
        pulse(v); wait_result(v, "t2b"); ack("t2b");
        v = '0;
        pulse(v); wait_result(v, "t6"); ack("t6");

        v = mk('{3, 7, 2, 9, 1, 0, 17, 5, 6, 4});
        pulse(v); wait_result(v, "b2b_a");
        v = mk('{1, 2, 3, 4, 5, 6, 7, 8, 9, 31});
        scores_i = v;
        start_i = 1'b1;
        ro.ready = 1'b1;
        @(negedge usb_clk);
        start_i = 1'b0;
        ro.ready = 1'b0;
        chk("b2b_vdrop", ro.valid, 0);
        chk("b2b_busy", busy_o, 1);
        chk("b2b_held", ro.class_id, 6);
        wait_result(v, "b2b_b");
        chk("b2b_ovr", overrun_o, 0);
        ack("b2b_b");

        v = mk('{3, 7, 2, 9, 1, 0, 17, 5, 6, 4});
        pulse(v);
        repeat (3) @(negedge usb_clk);
        rst = 1'b1;
        #1;
        chk("mid_busy", busy_o, 0);
        chk("mid_valid", ro.valid, 0);
        chk("mid_cls", ro.class_id, 0);
        chk("mid_score", ro.score, 0);
        chk("mid_tie", ro.tie, 0);
        chk("mid_margin", ro.margin, 0);
        @(negedge usb_clk);
        rst = 1'b0;
        @(negedge usb_clk);
        pulse(v); wait_result(v, "t5"); ack("t5");

        for (int it = 0; it < 16; it++) begin
            for (int i = 0; i < N_CLASSES; i++)
                v[i] = score_t'(it % 2 ? $urandom_range(0, 31) : $urandom_range(0, 3));
            pulse(v);
            wait_result(v, "rnd");
            repeat ($urandom_range(0, 3)) @(negedge usb_clk);
            chk("rnd_hold", ro.valid, 1);
            ack("rnd");
        end
        chk("pre_ovr", overrun_o, 0);

        v = mk('{4, 4, 11, 0, 30, 2, 29, 7, 8, 1});
        pulse(v); wait_result(v, "bp");
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < N_CLASSES; k++) hold_v[k] = score_t'($urandom_range(0, 31));
            scores_i = hold_v;
            start_i = (i == 2);
            @(negedge usb_clk);
        end
        start_i = 1'b0;
        chk("bp_valid", ro.valid, 1);
        chk("bp_cls", ro.class_id, exp_c);
        chk("bp_score", ro.score, exp_s);
        chk("bp_margin", ro.margin, exp_m);
        chk("bp_ovr", overrun_o, 1);
        ack("bp");
        @(negedge usb_clk);
        chk("bp_single", ro.valid, 0);
        chk("bp_ovr_sticky", overrun_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
